spinner_bank: RTL and testbench

Multi-channel, frame-strobed rotary/spinner emulator for arcade control inputs. It is the parametrised successor of the single-channel `spinner`. It converts digital CW/CCW buttons or signed analog stick values into per-channel WIDTH-bit wrapping angle counters, with optional hold-acceleration. Channels are updated once per video frame, time-multiplexed one channel per clock, and feed game input ports (Tron, Two Tigers, Krooz'r, Wacko style).

---
 rtl/spinner_bank_if.sv | 27 ++
 rtl/spinner_bank.sv | 160 ++++++++++++++++
 tb/tb_spinner_bank.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/spinner_bank_if.sv
// Control/status bundle between the input front end and the spinner bank.
// The master side drives strobe and buttons; the slave side (spinner_bank) returns angles and status.
interface spinner_bank_if #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 8
);
    logic                      strobe;
    logic [CHANNELS-1:0]       plus;
    logic [CHANNELS-1:0]       minus;
    logic [CHANNELS-1:0]       use_spinner;
    logic [CHANNELS-1:0]       analog_en;
    logic [8*CHANNELS-1:0]     analog;
    logic [WIDTH*CHANNELS-1:0] spin_angle;
    logic [CHANNELS-1:0]       dir;
    logic                      busy;
    logic                      frame_done;

    modport master (
        output strobe, plus, minus, use_spinner, analog_en, analog,
        input  spin_angle, dir, busy, frame_done
    );

    modport slave (
        input  strobe, plus, minus, use_spinner, analog_en, analog,
        output spin_angle, dir, busy, frame_done
    );
endinterface

// File: rtl/spinner_bank.sv
// Frame-strobed multi-channel spinner emulator: one channel's angle is updated per clock
// during a sweep that starts on each rising edge of the frame strobe.
//
//   state   | meaning
//   S_IDLE  | waiting for a strobe rising edge
//   S_SWEEP | updating channel idx_q this cycle
//   S_DONE  | frame_done pulse; restart if an edge is pending
module spinner_bank #(
    parameter int CHANNELS  = 2,
    parameter int WIDTH     = 8,
    parameter int STEP_MIN  = 1,
    parameter int STEP_MAX  = 4,
    parameter int DEADZONE  = 8,
    parameter int ANA_SHIFT = 3,
    parameter int CENTER    = 0
) (
    input  logic           clk,
    input  logic           reset,
    spinner_bank_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int AW    = (WIDTH > 8) ? WIDTH : 8;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(CHANNELS - 1);
    localparam logic [WIDTH-1:0] STEP_MIN_W = WIDTH'(STEP_MIN);
    localparam logic [WIDTH-1:0] STEP_MAX_W = WIDTH'(STEP_MAX);
    localparam logic [WIDTH-1:0] CENTER_W   = WIDTH'(CENTER);
    localparam logic [8:0]       DEAD_W     = 9'(DEADZONE);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               pending_q, pending_d;
    logic               strobe_q;
    logic               strobe_rise;

    logic [WIDTH-1:0]   angle_q [CHANNELS];
    logic [WIDTH-1:0]   step_q  [CHANNELS];
    logic [CHANNELS-1:0] dir_q;

    logic signed [7:0]    ana;
    logic [8:0]           ana_mag;
    logic signed [AW-1:0] ana_ext;
    logic signed [AW-1:0] ana_shift;
    logic [WIDTH-1:0]     step_cur;
    logic [WIDTH-1:0]     delta;
    logic [WIDTH-1:0]     step_d;
    logic [WIDTH-1:0]     angle_d;
    logic                 dir_d;
    logic                 btn_p, btn_m;

    assign strobe_rise = bus.strobe & ~strobe_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        case (state_q)
            S_IDLE: begin
                if (strobe_rise) begin
                    state_d = S_SWEEP;
                    idx_d   = '0;
                end
            end
            S_SWEEP: begin
                // only one edge can be remembered; later ones merge into it
                if (strobe_rise) pending_d = 1'b1;
                if (idx_q == IDX_LAST) state_d = S_DONE;
                else                   idx_d   = idx_q + IDX_W'(1);
            end
            S_DONE: begin
                idx_d = '0;
                if (pending_q || strobe_rise) begin
                    state_d   = S_SWEEP;
                    pending_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                idx_d     = '0;
                pending_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        bus.busy       = (state_q == S_SWEEP);
        bus.frame_done = (state_q == S_DONE);
    end

    always_comb begin
        ana       = signed'(bus.analog[8*idx_q +: 8]);
        // -128 folds to a magnitude of 128 thanks to the 9-bit negate
        ana_mag   = ana[7] ? (9'd0 - {ana[7], ana}) : {1'b0, ana};
        ana_ext   = AW'(ana);
        ana_shift = ana_ext >>> ANA_SHIFT;
        btn_p     = bus.plus[idx_q];
        btn_m     = bus.minus[idx_q];
        step_cur  = step_q[idx_q];
        delta     = '0;
        step_d    = step_cur;
        dir_d     = dir_q[idx_q];
        if (bus.analog_en[idx_q] && (ana_mag > DEAD_W)) begin
            delta = ana_shift[WIDTH-1:0];
            dir_d = ~ana[7];
        end else if (btn_p && btn_m) begin
            step_d = STEP_MIN_W;
        end else if (btn_p || btn_m) begin
            delta = btn_p ? step_cur : ('0 - step_cur);
            dir_d = btn_p;
            if (bus.use_spinner[idx_q])
                step_d = (step_cur < STEP_MAX_W) ? step_cur + WIDTH'(1) : STEP_MAX_W;
            else
                step_d = STEP_MIN_W;
        end else begin
            step_d = STEP_MIN_W;
        end
        if (delta == '0) dir_d = dir_q[idx_q];
        angle_d = angle_q[idx_q] + delta;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_q <= 1'b0;
            dir_q    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                angle_q[i] <= CENTER_W;
                step_q[i]  <= STEP_MIN_W;
            end
        end else begin
            strobe_q <= bus.strobe;
            if (state_q == S_SWEEP) begin
                angle_q[idx_q] <= angle_d;
                step_q[idx_q]  <= step_d;
                dir_q[idx_q]   <= dir_d;
            end
        end
    end

    always_comb begin
        bus.spin_angle = '0;
        for (int i = 0; i < CHANNELS; i++)
            bus.spin_angle[WIDTH*i +: WIDTH] = angle_q[i];
        bus.dir = dir_q;
    end
endmodule

// File: tb/tb_spinner_bank.sv
// Directed bench for spinner_bank: a 2-channel instance for function and timing,
// plus a 4-channel instance sharing the strobe to exercise the dropped-edge case.
module tb_spinner_bank;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spinner_bank_if #(.CHANNELS(2), .WIDTH(8)) bus ();
    spinner_bank_if #(.CHANNELS(4), .WIDTH(8)) bus4 ();

    spinner_bank dut (.clk(clk), .reset(reset), .bus(bus));
    spinner_bank #(.CHANNELS(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ang(input int k);
        return bus.spin_angle[8*k +: 8];
    endfunction

    // one-cycle strobe, then wait (bounded) for the frame_done pulse
    task automatic do_frame();
        bit seen = 1'b0;
        @(negedge clk) bus.strobe = 1'b1;
        @(negedge clk) bus.strobe = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.frame_done) seen = 1'b1;
            else @(negedge clk);
        end
        check_val("frame_done_seen", 32'(seen), 32'd1);
        @(negedge clk);
    endtask

    // drive the same strobe pattern into both instances, one bit per cycle, counting pulses
    task automatic run_pattern(input logic [15:0] pat, output int fd2, output int fd4);
        fd2 = 0;
        fd4 = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.strobe  = pat[i];
            bus4.strobe = pat[i];
            fd2 += int'(bus.frame_done);
            fd4 += int'(bus4.frame_done);
        end
        bus.strobe  = 1'b0;
        bus4.strobe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int fd2, fd4;
        logic [7:0] acc_exp [5] = '{8'd1, 8'd3, 8'd6, 8'd10, 8'd14};
        logic [7:0] dn_exp  [4] = '{8'hFF, 8'hFE, 8'hFD, 8'hFC};
        logic [7:0] up_exp  [3] = '{8'hFD, 8'hFF, 8'h02};

        reset = 1'b1;
        bus.strobe = 1'b0; bus.plus = '0; bus.minus = '0;
        bus.use_spinner = '0; bus.analog_en = '0; bus.analog = '0;
        bus4.strobe = 1'b0; bus4.plus = '0; bus4.minus = '0;
        bus4.use_spinner = '0; bus4.analog_en = '0; bus4.analog = '0;
        repeat (3) @(negedge clk);
        check_val("rst_angle", 32'(bus.spin_angle), 32'h0);
        check_val("rst_dir", 32'(bus.dir), 32'h0);
        check_val("rst_busy", 32'(bus.busy), 32'h0);
        check_val("rst_fd", 32'(bus.frame_done), 32'h0);
        reset = 1'b0;

        // sweep timing with no inputs
        @(negedge clk) bus.strobe = 1'b1;
        @(negedge clk) bus.strobe = 1'b0;
        check_val("busy_n1", 32'(bus.busy), 32'd1);
        check_val("fd_n1", 32'(bus.frame_done), 32'd0);
        @(negedge clk);
        check_val("busy_n2", 32'(bus.busy), 32'd1);
        check_val("fd_n2", 32'(bus.frame_done), 32'd0);
        @(negedge clk);
        check_val("busy_n3", 32'(bus.busy), 32'd0);
        check_val("fd_n3", 32'(bus.frame_done), 32'd1);
        @(negedge clk);
        check_val("fd_n4", 32'(bus.frame_done), 32'd0);
        check_val("idle_angles", 32'(bus.spin_angle), 32'h0);

        // accelerated hold on channel 0: deltas 1,2,3,4,4
        bus.plus[0] = 1'b1; bus.use_spinner[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_frame();
            check_val("accel_a0", 32'(ang(0)), 32'(acc_exp[i]));
        end
        check_val("accel_a1", 32'(ang(1)), 32'h0);
        check_val("accel_dir0", 32'(bus.dir[0]), 32'd1);
        bus.plus[0] = 1'b0;
        do_frame();
        check_val("release_a0", 32'(ang(0)), 32'd14);

        // fixed-step minus on channel 1 wraps below zero
        bus.minus[1] = 1'b1; bus.use_spinner[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_frame();
            check_val("minus_a1", 32'(ang(1)), 32'(dn_exp[i]));
        end
        check_val("minus_dir1", 32'(bus.dir[1]), 32'd0);
        bus.minus[1] = 1'b0;

        // analog on channel 0
        bus.analog_en[0] = 1'b1;
        bus.analog[7:0] = 8'd64;  do_frame(); check_val("ana_p64", 32'(ang(0)), 32'd22);
        bus.analog[7:0] = 8'd5;   do_frame(); check_val("ana_5", 32'(ang(0)), 32'd22);
        bus.analog[7:0] = 8'h80;  do_frame(); check_val("ana_m128", 32'(ang(0)), 32'd6);
        check_val("ana_dir_neg", 32'(bus.dir[0]), 32'd0);
        bus.analog[7:0] = 8'd64; bus.plus[0] = 1'b1;
        do_frame(); check_val("ana_beats_btn", 32'(ang(0)), 32'd14);
        check_val("ana_dir_pos", 32'(bus.dir[0]), 32'd1);
        bus.plus[0] = 1'b0;
        bus.analog[7:0] = 8'd8;   do_frame(); check_val("ana_dz_edge", 32'(ang(0)), 32'd14);
        bus.analog[7:0] = 8'd9;   do_frame(); check_val("ana_dz_plus1", 32'(ang(0)), 32'd15);
        bus.analog[7:0] = 8'hF7;  do_frame(); check_val("ana_m9", 32'(ang(0)), 32'd13);
        bus.analog_en[0] = 1'b0; bus.analog[7:0] = 8'd64;
        do_frame(); check_val("ana_disabled", 32'(ang(0)), 32'd13);

        // both buttons: no motion and step returns to STEP_MIN
        bus.plus[0] = 1'b1;
        do_frame(); check_val("both_pre1", 32'(ang(0)), 32'd14);
        do_frame(); check_val("both_pre2", 32'(ang(0)), 32'd16);
        bus.minus[0] = 1'b1;
        do_frame(); check_val("both_hold", 32'(ang(0)), 32'd16);
        bus.minus[0] = 1'b0;
        do_frame(); check_val("both_step_reset", 32'(ang(0)), 32'd17);
        bus.plus[0] = 1'b0;

        // accelerated plus on channel 1 wraps past the top
        bus.plus[1] = 1'b1; bus.use_spinner[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_frame();
            check_val("up_wrap_a1", 32'(ang(1)), 32'(up_exp[i]));
        end
        check_val("up_dir1", 32'(bus.dir[1]), 32'd1);
        bus.plus[1] = 1'b0;

        // edges at N, N+2, N+4: 2-ch sweeps three times, 4-ch drops the third edge
        bus.use_spinner[0] = 1'b0; bus.plus[0] = 1'b1;
        run_pattern(16'b0000_0000_0001_0101, fd2, fd4);
        check_val("pend_fd_2ch", 32'(fd2), 32'd3);
        check_val("pend_fd_4ch", 32'(fd4), 32'd2);
        check_val("pend_a0", 32'(ang(0)), 32'd20);

        // strobe held high gives one sweep
        run_pattern(16'b0000_1111_1111_1111, fd2, fd4);
        check_val("held_fd_2ch", 32'(fd2), 32'd1);
        check_val("held_fd_4ch", 32'(fd4), 32'd1);
        check_val("held_a0", 32'(ang(0)), 32'd21);
        check_val("held_a1", 32'(ang(1)), 32'h02);

        // reset during cycle N+1 aborts the sweep before channel 0 is written
        @(negedge clk) bus.strobe = 1'b1;
        @(negedge clk) begin bus.strobe = 1'b0; reset = 1'b1; end
        @(negedge clk);
        check_val("abort_angles", 32'(bus.spin_angle), 32'h0);
        check_val("abort_busy", 32'(bus.busy), 32'd0);
        check_val("abort_fd", 32'(bus.frame_done), 32'd0);
        check_val("abort_dir", 32'(bus.dir), 32'd0);
        reset = 1'b0;
        fd2 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            fd2 += int'(bus.frame_done);
        end
        check_val("abort_no_fd", 32'(fd2), 32'd0);
        check_val("abort_a0_after", 32'(ang(0)), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
